// File: rtl/negbus_device_receiver.sv
// Device-side responder for the PDP-8/I negative I/O bus: skip on flag, clear flag, load buffer.
// Define NEGBUS_INT_EN to add the interrupt-enable register and the int_rq_n output.
module negbus_device_receiver #(
    parameter logic [5:0]  DEV_CODE    = 6'o34,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:5]  bmb_n,
    input  logic [0:11] bac_n,
    input  logic        iop1_n,
    input  logic        iop2_n,
    input  logic        iop4_n,
    input  logic        initialize_n,
    output logic        skip_n,
`ifdef NEGBUS_INT_EN
    output logic        int_rq_n,
`endif
    output logic [0:11] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        flag
);

    localparam int unsigned BUS_W = 22;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    logic [0:5]       w_bmb_a;
    logic [0:11]      w_bac_a;
    logic [2:0]       w_iop_a;
    logic             w_init_a;
    logic [BUS_W-1:0] w_bus_a;

    logic [BUS_W-1:0] r_sync [SYNC_STAGES];

    logic [0:5]       w_bmb_s;
    logic [0:11]      w_bac_s;
    logic [2:0]       w_iop_s;
    logic             w_init_s;
    logic             w_sel;
    logic [2:0]       w_iop_rise;

    logic [2:0]       r_iop_d;
    logic             r_cmd2;
    logic             r_cmd4;
    state_t           r_state;
    logic             r_valid;
    logic [0:11]      r_data;
    logic             r_flag;
    logic             r_skip;
`ifdef NEGBUS_INT_EN
    logic             r_ie;
    logic             r_int;
`endif

    // Only a hard low counts as asserted; floating or unknown bus lines read as negated.
    always_comb begin
        w_bmb_a = '0;
        w_bac_a = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            w_bmb_a[i] = (bmb_n[i] === 1'b0);
        end
        for (int unsigned i = 0; i < 12; i++) begin
            w_bac_a[i] = (bac_n[i] === 1'b0);
        end
        w_iop_a[0] = (iop1_n === 1'b0);
        w_iop_a[1] = (iop2_n === 1'b0);
        w_iop_a[2] = (iop4_n === 1'b0);
        w_init_a   = (initialize_n === 1'b0);
    end

    assign w_bus_a = {w_bmb_a, w_bac_a, w_iop_a, w_init_a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_bus_a;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_bmb_s  = r_sync[SYNC_STAGES-1][21:16];
    assign w_bac_s  = r_sync[SYNC_STAGES-1][15:4];
    assign w_iop_s  = r_sync[SYNC_STAGES-1][3:1];
    assign w_init_s = r_sync[SYNC_STAGES-1][0];

    assign w_sel      = (w_bmb_s == DEV_CODE);
    assign w_iop_rise = w_iop_s & ~r_iop_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iop_d <= '0;
        end else begin
            r_iop_d <= w_iop_s;
        end
    end

    // Command pulses are registered, so skip samples the flag one cycle before a load can clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd2  <= 1'b0;
            r_cmd4  <= 1'b0;
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flag  <= 1'b0;
            r_skip  <= 1'b0;
`ifdef NEGBUS_INT_EN
            r_ie    <= 1'b1;
            r_int   <= 1'b0;
`endif
        end else if (w_init_s) begin
            r_cmd2  <= 1'b0;
            r_cmd4  <= 1'b0;
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flag  <= 1'b0;
            r_skip  <= 1'b0;
`ifdef NEGBUS_INT_EN
            r_ie    <= 1'b1;
            r_int   <= 1'b0;
`endif
        end else begin
            r_cmd2 <= w_iop_rise[1] & w_sel;
            r_cmd4 <= w_iop_rise[2] & w_sel;
            r_skip <= w_iop_s[0] & w_sel & r_flag;
`ifdef NEGBUS_INT_EN
            r_int  <= r_flag & r_ie;
`endif

            if (r_cmd2) begin
                r_flag <= 1'b0;
`ifdef NEGBUS_INT_EN
                r_ie   <= w_bac_s[11];
`endif
            end

            // Later assignments take priority: completion beats CLF, a new load beats completion.
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                end
                ST_BUSY: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_flag  <= 1'b1;
                    end
                end
            endcase

            if (r_cmd4) begin
                r_data  <= w_bac_s;
                r_flag  <= 1'b0;
                r_state <= ST_BUSY;
                r_valid <= 1'b1;
            end
        end
    end

    assign skip_n    = r_skip ? 1'b0 : 1'bz;
`ifdef NEGBUS_INT_EN
    assign int_rq_n  = r_int ? 1'b0 : 1'bz;
`endif
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign flag      = r_flag;

endmodule

// File: tb/tb_negbus_device_receiver.sv
// Directed bench for negbus_device_receiver; open-collector outputs are read through pull-ups.
module tb_negbus_device_receiver;

    localparam int unsigned SS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:5]  bmb_n = '1;
    logic [0:11] bac_n = '1;
    logic        iop1_n = 1'b1;
    logic        iop2_n = 1'b1;
    logic        iop4_n = 1'b1;
    logic        initialize_n = 1'b1;
    logic        out_ready = 1'b0;
    logic [0:11] out_data;
    logic        out_valid;
    logic        flag;

    wire w_skip_n;
    pullup pu_skip (w_skip_n);
`ifdef NEGBUS_INT_EN
    wire w_int_rq_n;
    pullup pu_int (w_int_rq_n);
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    negbus_device_receiver #(
        .DEV_CODE    (6'o34),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bmb_n        (bmb_n),
        .bac_n        (bac_n),
        .iop1_n       (iop1_n),
        .iop2_n       (iop2_n),
        .iop4_n       (iop4_n),
        .initialize_n (initialize_n),
        .skip_n       (w_skip_n),
`ifdef NEGBUS_INT_EN
        .int_rq_n     (w_int_rq_n),
`endif
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .flag         (flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives true-sense values onto the low-true bus.
    task automatic set_bus(input logic [5:0] code, input logic [11:0] word);
        bmb_n = ~code;
        bac_n = ~word;
    endtask

    task automatic load_word(input logic [11:0] word);
        set_bus(6'o34, word);
        iop4_n = 1'b0;
        tick(SS + 2);
        iop4_n = 1'b1;
        tick(SS + 1);
    endtask

    task automatic complete();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_valid", out_valid, 0);
        check("rst_flag", flag, 0);
        check("rst_data", out_data, 0);
        check("rst_skip", w_skip_n, 1);
`ifdef NEGBUS_INT_EN
        check("rst_int", w_int_rq_n, 1);
`endif

        // Load 5252, check latency, hold while not ready, then accept
        set_bus(6'o34, 12'o5252);
        tick(1);
        iop4_n = 1'b0;
        tick(SS + 1);
        check("ld_early_valid", out_valid, 0);
        tick(1);
        check("ld_valid", out_valid, 1);
        check("ld_data", out_data, 12'o5252);
        check("ld_flag", flag, 0);
        iop4_n = 1'b1;
        set_bus(6'o34, 12'o0000);
        tick(3);
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, 12'o5252);
        complete();
        check("acc_valid", out_valid, 0);
        check("acc_flag", flag, 1);

        // Skip with selected device, latency on assert and release
        iop1_n = 1'b0;
        tick(SS);
        check("skip_early", w_skip_n, 1);
        tick(1);
        check("skip_on", w_skip_n, 0);
        tick(2);
        check("skip_hold", w_skip_n, 0);
        iop1_n = 1'b1;
        tick(SS);
        check("skip_rel_hold", w_skip_n, 0);
        tick(1);
        check("skip_off", w_skip_n, 1);

        // Unselected device code: neither skip nor load respond
        set_bus(6'o35, 12'o7070);
        iop1_n = 1'b0;
        tick(SS + 1);
        check("skip_unsel", w_skip_n, 1);
        tick(2);
        check("skip_unsel_end", w_skip_n, 1);
        iop1_n = 1'b1;
        tick(SS + 1);
        iop4_n = 1'b0;
        tick(SS + 2);
        check("uns_valid", out_valid, 0);
        check("uns_data", out_data, 12'o5252);
        check("uns_flag", flag, 1);
        iop4_n = 1'b1;
        tick(SS + 1);

        // CLF landing on the completion cycle: flag set wins
        load_word(12'o1111);
        check("race_pre_valid", out_valid, 1);
        set_bus(6'o34, 12'o0001);
        iop2_n = 1'b0;
        tick(SS + 1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("race_flag", flag, 1);
        check("race_valid", out_valid, 0);
        iop2_n = 1'b1;
        tick(SS + 1);
        check("race_flag_after", flag, 1);
        iop2_n = 1'b0;
        tick(SS + 2);
        check("clf_flag", flag, 0);
        iop2_n = 1'b1;
        tick(SS + 1);

        // out_ready in IDLE has no effect
        out_ready = 1'b1;
        tick(2);
        check("idle_rdy_flag", flag, 0);
        check("idle_rdy_valid", out_valid, 0);
        out_ready = 1'b0;

        // Overwrite while BUSY, then a single accept
        load_word(12'o1234);
        check("ov_data1", out_data, 12'o1234);
        load_word(12'o7777);
        check("ov_data2", out_data, 12'o7777);
        check("ov_valid", out_valid, 1);
        check("ov_flag", flag, 0);
        complete();
        check("ov_acc_valid", out_valid, 0);
        check("ov_acc_flag", flag, 1);
        tick(3);
        check("ov_once_valid", out_valid, 0);

        // New load on the completion cycle: load wins
        load_word(12'o4321);
        set_bus(6'o34, 12'o0707);
        iop4_n = 1'b0;
        tick(SS + 1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        iop4_n = 1'b1;
        check("lw_valid", out_valid, 1);
        check("lw_data", out_data, 12'o0707);
        check("lw_flag", flag, 0);
        tick(SS + 1);
        complete();
        check("lw_done_flag", flag, 1);

`ifdef NEGBUS_INT_EN
        tick(1);
        check("int_on", w_int_rq_n, 0);
        set_bus(6'o34, 12'o0000);
        iop2_n = 1'b0;
        tick(SS + 2);
        check("ie_clf_flag", flag, 0);
        iop2_n = 1'b1;
        tick(1);
        check("int_off", w_int_rq_n, 1);
        tick(SS);
        load_word(12'o0005);
        complete();
        tick(2);
        check("ie_done_flag", flag, 1);
        check("int_masked", w_int_rq_n, 1);
`endif

        // INITIALIZE aborts a pending handshake
        load_word(12'o2222);
        check("init_pre_valid", out_valid, 1);
        initialize_n = 1'b0;
        tick(3);
        check("init_valid", out_valid, 0);
        check("init_flag", flag, 0);
        check("init_data", out_data, 0);
        check("init_skip", w_skip_n, 1);
        initialize_n = 1'b1;
        tick(SS + 1);
        check("init_after_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
